cart_loader: RTL
================

# cart_loader

Cartridge download front end for the console cores. It sits between the HPS download stream and the cartridge ROM. It forwards download bytes into ROM with a one-cycle registered write, and learns the power-of-two address mask of the image, including images written out of order. It flags images too large for the ROM. It sequences core reset: reset is held during the download, and an optional delayed second reset pulse (skip-logo) fires after the download ends.

## Interface
- ADDR_W, 15: ROM address width in bits; the ROM holds 2^ADDR_W bytes.
- DELAY, 5000000: cycles from end of download to start of the second reset pulse; must be >= 1.
- PULSE, 1000: length of the second reset pulse in cycles; must be >= 1.

Ports:
- clk_sys  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- dl_active  in  1  download in progress (ioctl_download).
- dl_wr  in  1  byte strobe, one cycle per byte.
- dl_addr  in  25  byte address.
- dl_data  in  8  byte data.
- skip_en  in  1  second-reset enable; sampled on the cycle dl_active is seen low in LOAD.
- cpu_addr  in  ADDR_W  core cartridge address.
- cpu_addr_m  out  ADDR_W  cpu_addr & addr_mask; combinational (mirroring).
- rom_we  out  1  ROM write strobe.
- rom_addr  out  ADDR_W  ROM write address.
- rom_data  out  8  ROM write data.
- addr_mask  out  ADDR_W  learned mask.
- last_addr  out  ADDR_W  highest accepted address.
- overflow  out  1  sticky: some write addressed at or beyond 2^ADDR_W.
- core_reset  out  1  active-high reset to the core.
- ready  out  1  image loaded and core released.

## Operation
States and transitions:
- IDLE: the state after reset.
  - core_reset=0, ready=0.
  - dl_active=1 -> LOAD.
- LOAD: core_reset=1.
  - dl_active=0 with skip_en=1 -> WAIT, with the counter loaded to DELAY-1.
  - dl_active=0 with skip_en=0 -> READY.
- WAIT: core_reset=0.
  - Counter decrements each cycle.
  - At 0 -> PULSE, with the counter loaded to PULSE-1.
- PULSE: core_reset=1.
  - Counter decrements.
  - At 0 -> READY.
- READY: ready=1.
  - dl_active=1 -> LOAD.
- Abort: dl_active=1 in WAIT or PULSE -> LOAD, abandoning the count; no pulse is issued.

Download start (any state other than LOAD with dl_active=1):
- addr_mask, last_addr and overflow are cleared.
- A write in that same cycle is evaluated against the cleared values.

Write acceptance: dl_active & dl_wr.
- If dl_addr[24:ADDR_W] != 0:
  - overflow is set.
  - No rom_we is issued.
  - addr_mask and last_addr are unchanged.
- Otherwise, with a = dl_addr[ADDR_W-1:0]:
  - rom_we/rom_addr/rom_data are issued.
  - addr_mask <= smear(addr_mask | a), where smear sets every bit at or below the highest set bit.
  - last_addr <= max(last_addr, a).
- dl_wr with dl_active=0 is ignored.

Learned state:
- addr_mask, last_addr and overflow hold after the download until the next download start or reset.
- An image written only at address 0 yields mask 0.

Reset (reset_n=0 on a clock edge):
- State becomes IDLE.
- Every output register goes to 0: rom_we, rom_addr, rom_data, addr_mask, last_addr, overflow, core_reset, ready.
- The counter goes to 0.
- Reset in any state, including mid-download, aborts with no ROM write issued for the reset cycle.
- After release with dl_active still high, the block goes to LOAD and the learned state is re-cleared.

## Timing
- All outputs except cpu_addr_m are registered.
- Write path: dl_wr at edge N produces rom_we high for exactly one cycle after edge N, and addr_mask/last_addr updated after the same edge N. Back-to-back strobes give back-to-back rom_we.
- core_reset rises one cycle after dl_active is first sampled high. The top level ORs in dl_active combinationally when zero-latency reset is needed.
- skip_en=1: core_reset drops after the edge that samples dl_active low, stays low exactly DELAY cycles, then is high exactly PULSE cycles. ready rises on the cycle core_reset falls.
- skip_en=0: core_reset falls and ready rises on the same edge, one cycle after dl_active is sampled low.
- Counter width is $clog2(max(DELAY,PULSE)+1).
- The last byte strobe may coincide with dl_active falling; that strobe is ignored (dl_active=0).

## Test plan
Run with ADDR_W=15, DELAY=20, PULSE=4.
- Sequential load of 0x0000..0x1FFF, skip_en=0:
  - 8192 rom_we pulses with matching data.
  - addr_mask=0x1FFF, last_addr=0x1FFF.
  - ready=1 one cycle after dl_active falls.
  - cpu_addr=0x2345 gives cpu_addr_m=0x0345.
- Out-of-order writes to 0x0003 then 0x1234 then 0x0010:
  - addr_mask=0x0003, then 0x1FFF, then 0x1FFF.
  - last_addr=0x1234.
- Write to dl_addr=0x8000:
  - overflow=1, no rom_we, mask unchanged.
  - A new download clears overflow.
- skip_en=1:
  - core_reset high during the download, low 20 cycles, high 4 cycles, then ready=1.
  - A second download started in cycle 10 of WAIT re-enters LOAD with no pulse.
- reset_n=0 mid-download:
  - All outputs 0 next cycle.
  - On release with dl_active=1, core_reset=1 one cycle later and addr_mask=0 before the next write.
- Write strobe on the same cycle dl_active rises, at address 0x0100, after a prior 0x7FFF image:
  - addr_mask=0x01FF, not 0x7FFF.

Source files
------------

// File: rtl/cart_loader_if.sv
// Download stream from the HPS and the registered ROM write port it turns into.
// The master drives the download signals; the slave (cart_loader) drives the ROM write.
interface cart_loader_if #(
    parameter int ADDR_W = 15
);
    logic              dl_active;
    logic              dl_wr;
    logic [24:0]       dl_addr;
    logic [7:0]        dl_data;
    logic              rom_we;
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_data;

    modport master (
        output dl_active, dl_wr, dl_addr, dl_data,
        input  rom_we, rom_addr, rom_data
    );

    modport slave (
        input  dl_active, dl_wr, dl_addr, dl_data,
        output rom_we, rom_addr, rom_data
    );
endinterface

// File: rtl/cart_loader.sv
// Cartridge download front end: forwards download bytes to ROM, learns the image
// address mask, flags oversize images and sequences the core reset (optional skip-logo pulse).
module cart_loader #(
    parameter int ADDR_W = 15,
    parameter int DELAY  = 5000000,
    parameter int PULSE  = 1000
) (
    input  logic              clk_sys_i,
    input  logic              reset_n_i,
    cart_loader_if.slave      bus,
    input  logic              skip_en_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    output logic [ADDR_W-1:0] cpu_addr_m_o,
    output logic [ADDR_W-1:0] addr_mask_o,
    output logic [ADDR_W-1:0] last_addr_o,
    output logic              overflow_o,
    output logic              core_reset_o,
    output logic              ready_o
);

    localparam int CNT_MAX = (DELAY > PULSE) ? DELAY : PULSE;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
    localparam logic [CNT_W-1:0] DELAY_LOAD = CNT_W'(DELAY - 1);
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_PULSE = 3'd3,
        ST_READY = 3'd4
    } state_e;

    // Sets every bit at or below the highest set bit, giving a power-of-two-minus-one mask.
    function automatic logic [ADDR_W-1:0] smear(input logic [ADDR_W-1:0] v);
        logic [ADDR_W-1:0] r;
        r = v;
        for (int i = ADDR_W - 2; i >= 0; i--) begin
            r[i] = r[i] | r[i+1];
        end
        return r;
    endfunction

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              rom_we_q, rom_we_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [7:0]        rom_data_q, rom_data_d;
    logic [ADDR_W-1:0] addr_mask_q, addr_mask_d;
    logic [ADDR_W-1:0] last_addr_q, last_addr_d;
    logic              overflow_q, overflow_d;
    logic              core_reset_q;
    logic              ready_q;

    logic              dl_start_s;
    logic              wr_acc_s;
    logic              oob_s;
    logic [ADDR_W-1:0] wr_addr_s;
    logic [ADDR_W-1:0] mask_base_s;
    logic [ADDR_W-1:0] last_base_s;
    logic              ovf_base_s;

    // Write path and learned image state; a download start clears the learned state
    // before the same-cycle write is folded in.
    always_comb begin
        dl_start_s  = bus.dl_active && (state_q != ST_LOAD);
        wr_acc_s    = bus.dl_active && bus.dl_wr;
        oob_s       = |bus.dl_addr[24:ADDR_W];
        wr_addr_s   = bus.dl_addr[ADDR_W-1:0];
        mask_base_s = dl_start_s ? {ADDR_W{1'b0}} : addr_mask_q;
        last_base_s = dl_start_s ? {ADDR_W{1'b0}} : last_addr_q;
        ovf_base_s  = dl_start_s ? 1'b0 : overflow_q;

        rom_we_d    = 1'b0;
        rom_addr_d  = rom_addr_q;
        rom_data_d  = rom_data_q;
        addr_mask_d = mask_base_s;
        last_addr_d = last_base_s;
        overflow_d  = ovf_base_s;

        if (wr_acc_s) begin
            if (oob_s) begin
                overflow_d = 1'b1;
            end else begin
                rom_we_d    = 1'b1;
                rom_addr_d  = wr_addr_s;
                rom_data_d  = bus.dl_data;
                addr_mask_d = smear(mask_base_s | wr_addr_s);
                if (wr_addr_s > last_base_s) begin
                    last_addr_d = wr_addr_s;
                end else begin
                    last_addr_d = last_base_s;
                end
            end
        end else begin
            rom_we_d = 1'b0;
        end
    end

    // Output registers and the reset-sequencing state machine.
    always_ff @(posedge clk_sys_i) begin
        if (!reset_n_i) begin
            state_q      <= ST_IDLE;
            cnt_q        <= CNT_ZERO;
            rom_we_q     <= 1'b0;
            rom_addr_q   <= {ADDR_W{1'b0}};
            rom_data_q   <= 8'h00;
            addr_mask_q  <= {ADDR_W{1'b0}};
            last_addr_q  <= {ADDR_W{1'b0}};
            overflow_q   <= 1'b0;
            core_reset_q <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            rom_we_q    <= rom_we_d;
            rom_addr_q  <= rom_addr_d;
            rom_data_q  <= rom_data_d;
            addr_mask_q <= addr_mask_d;
            last_addr_q <= last_addr_d;
            overflow_q  <= overflow_d;

            case (state_q)
                ST_IDLE: begin
                    ready_q <= 1'b0;
                    if (bus.dl_active) begin
                        state_q      <= ST_LOAD;
                        core_reset_q <= 1'b1;
                    end else begin
                        core_reset_q <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (!bus.dl_active) begin
                        core_reset_q <= 1'b0;
                        if (skip_en_i) begin
                            state_q <= ST_WAIT;
                            cnt_q   <= DELAY_LOAD;
                        end else begin
                            state_q <= ST_READY;
                            ready_q <= 1'b1;
                        end
                    end else begin
                        core_reset_q <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    // A new download abandons the count without issuing the pulse.
                    if (bus.dl_active) begin
                        state_q      <= ST_LOAD;
                        cnt_q        <= CNT_ZERO;
                        core_reset_q <= 1'b1;
                    end else if (cnt_q == CNT_ZERO) begin
                        state_q      <= ST_PULSE;
                        cnt_q        <= PULSE_LOAD;
                        core_reset_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                ST_PULSE: begin
                    if (bus.dl_active) begin
                        state_q      <= ST_LOAD;
                        cnt_q        <= CNT_ZERO;
                        core_reset_q <= 1'b1;
                    end else if (cnt_q == CNT_ZERO) begin
                        state_q      <= ST_READY;
                        core_reset_q <= 1'b0;
                        ready_q      <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                ST_READY: begin
                    if (bus.dl_active) begin
                        state_q      <= ST_LOAD;
                        core_reset_q <= 1'b1;
                        ready_q      <= 1'b0;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    cnt_q        <= CNT_ZERO;
                    core_reset_q <= 1'b0;
                    ready_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rom_we   = rom_we_q;
    assign bus.rom_addr = rom_addr_q;
    assign bus.rom_data = rom_data_q;

    assign cpu_addr_m_o = cpu_addr_i & addr_mask_q;
    assign addr_mask_o  = addr_mask_q;
    assign last_addr_o  = last_addr_q;
    assign overflow_o   = overflow_q;
    assign core_reset_o = core_reset_q;
    assign ready_o      = ready_q;

endmodule
